// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between the ALU and writeback.
// Runs one valid/grant/rvalid transaction per load/store on the data-memory
// port and returns aligned, sign/zero-extended load data.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_we/req_funct3    core request (held until done)
//   addr, wdata                    effective address, store data (rs2)
//   stall                          combinational: req_valid & ~done, 0 in reset
//   done, err, rdata               completion pulse, error flag, load result
//   mem_req/we/addr/be/wdata       memory request channel
//   mem_gnt, mem_rvalid, mem_rdata memory grant and read response
//
// Optional feature: define LSU_TIMEOUT_EN to abort a load with err after
// TIMEOUT cycles in WAIT without mem_rvalid.
module load_store_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata
);

    // Only a 4-lane 32-bit datapath and a non-zero timeout make sense.
    if (WIDTH != 32 || TIMEOUT == 0) begin : g_param_check
        $error("load_store_unit: WIDTH must be 32 and TIMEOUT non-zero");
    end

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic             done_nxt, err_nxt, mem_req_nxt;
    logic [WIDTH-1:0] rdata_nxt;
    logic             capture;

    logic             req_legal, req_aligned;
    logic [3:0]       req_be;
    logic [WIDTH-1:0] req_wd;

    logic [2:0]       cap_f3;
    logic [1:0]       cap_off;
    logic [WIDTH-1:0] lane, ld_ext;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt;
`endif

    // Stall the core while a request is pending and not yet completing.
    assign stall = rst_n & req_valid & ~done;

    // Request decode: funct3 legality and natural alignment.
    always_comb begin
        req_aligned = 1'b1;
        if (req_we) begin
            req_legal = (req_funct3[2] == 1'b0) && (req_funct3[1:0] != 2'b11);
        end else begin
            req_legal = (req_funct3[1:0] != 2'b11) && (req_funct3 != 3'b110);
        end
        case (req_funct3[1:0])
            2'b01:   req_aligned = (addr[0] == 1'b0);
            2'b10:   req_aligned = (addr[1:0] == 2'b00);
            default: req_aligned = 1'b1;
        endcase
    end

    // Byte enables and lane-replicated store data.
    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                req_be = 4'b0001 << addr[1:0];
                req_wd = {4{wdata[7:0]}};
            end
            2'b01: begin
                req_be = 4'b0011 << {addr[1], 1'b0};
                req_wd = {2{wdata[15:0]}};
            end
            default: begin
                req_be = 4'b1111;
                req_wd = wdata;
            end
        endcase
    end

    // Load extraction from the captured byte offset and size/sign code.
    always_comb begin
        lane = mem_rdata >> {cap_off, 3'b000};
        case (cap_f3)
            3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_ext = {24'b0, lane[7:0]};
            3'b101:  ld_ext = {16'b0, lane[15:0]};
            default: ld_ext = lane;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and next-output logic.
    always_comb begin
        state_nxt   = state;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        mem_req_nxt = 1'b0;
        rdata_nxt   = rdata;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_legal && req_aligned) begin
                        capture     = 1'b1;
                        mem_req_nxt = 1'b1;
                        state_nxt   = REQ;
                    end else begin
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            REQ: begin
                mem_req_nxt = 1'b1;
                if (mem_gnt) begin
                    mem_req_nxt = 1'b0;
                    if (mem_we) begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    rdata_nxt = ld_ext;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs and captured request fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0;
            mem_wdata <= '0;
            cap_f3    <= 3'b0;
            cap_off   <= 2'b0;
        end else begin
            done    <= done_nxt;
            err     <= err_nxt;
            rdata   <= rdata_nxt;
            mem_req <= mem_req_nxt;
            if (capture) begin
                mem_we    <= req_we;
                mem_addr  <= {addr[WIDTH-1:2], 2'b00};
                mem_be    <= req_be;
                mem_wdata <= req_wd;
                cap_f3    <= req_funct3;
                cap_off   <= addr[1:0];
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    // Cycles spent in WAIT; zero on the first WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state != WAIT) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit
// against a behavioural model of addresses, lanes, extension and latency.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] model_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Access size in bytes from funct3.
    function automatic int unsigned ref_size(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic bit ref_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        if (we && f3 > 3'd2) return 1'b0;
        if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        return (a % ref_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] m;
        m = 4'((32'd1 << ref_size(f3)) - 32'd1);
        return m << (a % 4);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
        if (ref_size(f3) == 1) return 32'(w[7:0]) * 32'h0101_0101;
        if (ref_size(f3) == 2) return 32'(w[15:0]) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] word);
        int unsigned sz;
        logic [31:0] v;
        sz = ref_size(f3);
        v  = word >> (8 * (a % 4));
        if (sz < 4) begin
            v = v % (32'd1 << (8 * sz));
            if (!f3[2] && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
        end
        return v;
    endfunction

    // Drive one request and act as the memory; returns in the done cycle
    // (negedge) with req_valid still high. b2b: request raised during the
    // previous done cycle. tmo: memory never answers the load.
    task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input int gd, input int rd,
                           input logic [31:0] word, input bit b2b, input bit tmo,
                           input string tag);
        bit ok, granted, got;
        int cyc, reqc, rvc, exp_lat;
        ok = ref_legal(we, f3, a);
        granted = 1'b0; got = 1'b0;
        cyc = b2b ? -1 : 0; reqc = 0; rvc = 0;
        if (!ok)      exp_lat = 1;
        else if (we)  exp_lat = 2 + gd;
        else if (tmo) exp_lat = 2 + gd + int'(TMO);
        else          exp_lat = 3 + gd + rd;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; addr = a; wdata = wd;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cyc++;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (done) begin
                got = 1'b1;
                break;
            end
            check({tag, " stall"}, 32'(stall), 32'd1);
            if (mem_req) begin
                check({tag, " mem_addr"}, mem_addr, a & 32'hFFFF_FFFC);
                check({tag, " mem_be"}, 32'(mem_be), 32'(ref_be(f3, a)));
                check({tag, " mem_we"}, 32'(mem_we), 32'(we));
                if (we) check({tag, " mem_wdata"}, mem_wdata, ref_wdata(f3, wd));
                if (reqc == gd) begin
                    mem_gnt = 1'b1;
                    granted = 1'b1;
                end else begin
                    mem_rvalid = 1'($urandom % 2);
                end
                reqc++;
            end else if (granted && !we && !tmo) begin
                if (rvc == rd) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = word;
                end
                rvc++;
            end
        end
        if (ok && !we && !tmo) model_rdata = ref_load(f3, a, word);
        check({tag, " done seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " err"}, 32'(err), 32'(!ok || tmo));
        check({tag, " rdata"}, rdata, model_rdata);
        check({tag, " req cycles"}, 32'(reqc), ok ? 32'(gd + 1) : 32'd0);
        check({tag, " stall at done"}, 32'(stall), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " stall"}, 32'(stall), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " err"}, 32'(err), 32'd0);
        check({tag, " rdata"}, rdata, 32'd0);
        check({tag, " mem_req"}, 32'(mem_req), 32'd0);
        check({tag, " mem_we"}, 32'(mem_we), 32'd0);
        check({tag, " mem_addr"}, mem_addr, 32'd0);
        check({tag, " mem_be"}, 32'(mem_be), 32'd0);
        check({tag, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic go_idle();
        req_valid = 1'b0;
        @(negedge clk);
        check("idle done", 32'(done), 32'd0);
    endtask

    initial begin
        bit          we, b2b;
        logic [2:0]  f3;
        logic [31:0] a;
        rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2;
        addr = 32'h0; wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        model_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(1'b0, 3'b010, 32'h0000_1004, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, "lw");
        check("lw rdata const", rdata, 32'hDEAD_BEEF);
        go_idle();
        run_txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 1, 32'h8012_3456, 1'b0, 1'b0, "lb");
        check("lb rdata const", rdata, 32'hFFFF_FF80);
        go_idle();
        run_txn(1'b0, 3'b100, 32'h0000_1003, 32'h0, 1, 0, 32'h8012_3456, 1'b0, 1'b0, "lbu");
        check("lbu rdata const", rdata, 32'h0000_0080);
        go_idle();
        run_txn(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 3, 0, 32'h0, 1'b0, 1'b0, "sh");
        check("sh keeps rdata", rdata, 32'h0000_0080);
        go_idle();
        run_txn(1'b0, 3'b010, 32'h0000_1001, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0, "lw misaligned");
        go_idle();
        run_txn(1'b0, 3'b011, 32'h0000_1000, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0, "funct3 011");
        go_idle();
        run_txn(1'b0, 3'b101, 32'h0000_3002, 32'h0, 1, 2, 32'hF00D_9ABC, 1'b0, 1'b0, "b2b lhu");
        run_txn(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 0, 0, 32'h0, 1'b1, 1'b0, "b2b sb");
        go_idle();

        // Reset while waiting for read data; a late rvalid must be ignored.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; addr = 32'h0000_4000;
        @(negedge clk);
        check("rst req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("rst wait no req", 32'(mem_req), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid reset");
        model_rdata = 32'h0;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("late rvalid done", 32'(done), 32'd0);
            check("late rvalid rdata", rdata, 32'd0);
            @(negedge clk);
        end

`ifdef LSU_TIMEOUT_EN
        run_txn(1'b0, 3'b010, 32'h0000_5000, 32'h0, 0, 0, 32'h0, 1'b0, 1'b1, "timeout");
        go_idle();
`endif

        for (int t = 0; t < 80; t++) begin
            we  = 1'($urandom % 2);
            f3  = 3'($urandom % 8);
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
            if ($urandom_range(0, 3) != 0 && f3[1]) a[1] = 1'b0;
            b2b = (t != 0) && ($urandom % 2 == 1);
            if (!b2b && t != 0) go_idle();
            run_txn(we, f3, a, $urandom, int'($urandom % 4), int'($urandom % 4),
                    $urandom, b2b, 1'b0, "rand");
        end
        go_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU in the RISC CPU.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs one valid/grant/rvalid transaction on the data-memory port.
- Returns aligned, sign- or zero-extended load data to writeback.
- Stalls the core via `stall` while a transaction is outstanding.

Parameters:
- WIDTH, 32, datapath/address width; only 32 is supported (4 byte lanes).
- TIMEOUT, 255, cycles to wait in WAIT before abort; used only with LSU_TIMEOUT_EN.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  core requests a load/store; held high until `done`.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I size/sign code.
- addr  input  WIDTH  effective address (ALU result).
- wdata  input  WIDTH  store data (rs2).
- stall  output  1  combinational: req_valid & ~done; forced 0 while rst_n low.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; misaligned, illegal funct3 or timeout.
- rdata  output  WIDTH  extended load data; registered, held until next done.
- mem_req  output  1  memory request valid.
- mem_we  output  1  memory write enable.
- mem_addr  output  WIDTH  word address {addr[31:2],2'b00}.
- mem_be  output  4  byte enables.
- mem_wdata  output  WIDTH  lane-replicated store data.
- mem_gnt  input  1  memory accepts the request this cycle.
- mem_rvalid  input  1  read data valid; never earlier than the cycle after gnt.
- mem_rdata  input  WIDTH  raw 32-bit read word.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE.
- Reset values: state IDLE; done, err, mem_req, mem_we = 0; mem_be, mem_addr, mem_wdata, rdata = 0.
- IDLE, req_valid = 1: capture we, funct3, addr, wdata in that cycle.
  - Legal and aligned → REQ.
  - Otherwise → DONE with err = 1 and no mem_req.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned: halfword with addr[0] = 1; word with addr[1:0] ≠ 0.
- REQ:
  - mem_req = 1; mem_we, mem_addr, mem_be, mem_wdata held stable until mem_gnt.
  - On gnt: store → DONE; load → WAIT.
  - mem_req drops in the cycle after gnt.
- WAIT: on mem_rvalid, register the extracted load into rdata → DONE.
- DONE: done = 1 for exactly one cycle → IDLE.
  - req_valid in the DONE cycle is ignored.
  - A still-high req_valid in the following IDLE cycle is taken as the next instruction.
- Byte enables:
  - SB = 4'b0001 << addr[1:0].
  - SH = 4'b0011 << {addr[1],1'b0}.
  - SW = 4'b1111.
  - Loads drive the same pattern.
- Store data: SB replicates wdata[7:0] ×4; SH replicates wdata[15:0] ×2; SW passes through.
- Load extraction: lane = mem_rdata >> (8*addr[1:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Stores leave rdata unchanged. Error completions leave rdata unchanged.
- Minimum latency from acceptance cycle T0, with gnt in the first REQ cycle:
  - Store: done at T2.
  - Load: rvalid at T2, done at T3.
- mem_rvalid outside WAIT is ignored.
- Reset mid-transaction: async return to IDLE with all outputs at reset values. A late rvalid after reset is ignored.

Optional Feature:
- Macro LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter clears on WAIT entry and increments each WAIT cycle.
  - On reaching TIMEOUT without rvalid → DONE with err = 1 and rdata unchanged.
- Undefined: no counter; WAIT waits indefinitely.

Test Plan:
- LW, addr 0x0000_1004, gnt immediate, rvalid next cycle with 0xDEAD_BEEF → mem_addr 0x1004, be 1111, done at T3, rdata 0xDEAD_BEEF, err 0.
- LB, addr 0x1003, rdata word 0x8012_3456 → be 1000, rdata 0xFFFF_FF80. Same with LBU → 0x0000_0080.
- SH, addr 0x2002, wdata 0x1234_ABCD, gnt delayed 3 cycles → mem_req held 3 cycles with stable fields, be 1100, mem_wdata 0xABCD_ABCD, mem_we 1, done 1 cycle after gnt.
- LW at 0x1001 and funct3 011 → done one cycle after acceptance, err 1, mem_req never asserted, stall high until done.
- Back-to-back: LHU then SB with req_valid held continuously → second request accepted in the IDLE cycle after the first done, no lost or duplicate access.
- rst_n pulsed low in WAIT, then stray rvalid → outputs reset immediately, rvalid ignored, no done. With LSU_TIMEOUT_EN and TIMEOUT 4: no rvalid → done + err exactly 4 cycles after WAIT entry.
